// File: rtl/scnn_wt_pkg.sv
// ---------------------------------------------------------------------------
// scnn_wt_pkg
// Shared definitions for the SCNN weight-stream scheduler slice.
//   DEF_WSIZE / DEF_F : default tile depth and beat width (lanes)
//   WT_W / IDX_W      : packed weight width and zero-run index width
//   wt_t / idx_t      : weight and index element types
//   sched_state_t     : scheduler FSM states
// Optional build macro used by this slice: SCNN_WT_ABS_POS_EN
// ---------------------------------------------------------------------------
package scnn_wt_pkg;

   localparam int DEF_WSIZE = 25;
   localparam int DEF_F     = 4;
   localparam int WT_W      = 16;
   localparam int IDX_W     = 8;

   typedef logic [WT_W-1:0]  wt_t;
   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } sched_state_t;

endpackage

// File: rtl/scnn_wt_beat_slice.sv
// ---------------------------------------------------------------------------
// scnn_wt_beat_slice
// Combinational lane selector: given the held tile, the beat pointer and the
// effective non-zero count, produces the PARAM_F lanes of the current beat.
//   ptr       in  index of the tile entry carried by lane 0
//   nz_eff    in  clamped non-zero count of the held tile
//   tile_wts  in  held packed weights
//   tile_ind  in  held zero-run indices
//   pos_base  in  (SCNN_WT_ABS_POS_EN) absolute position accumulator
//   pos_next  out (SCNN_WT_ABS_POS_EN) accumulator value for the next beat
//   lane_wts  out beat weights, 0 on invalid lanes
//   lane_ind  out beat indices (raw run or absolute position), 0 on invalid
//   lane_vld  out per-lane valid
//   last      out this beat finishes the tile
// Macro SCNN_WT_ABS_POS_EN selects absolute kernel positions on lane_ind.
// ---------------------------------------------------------------------------
module scnn_wt_beat_slice
   import scnn_wt_pkg::*;
#(
   parameter int PARAM_WSIZE = DEF_WSIZE,
   parameter int PARAM_F     = DEF_F,
   parameter int PTR_W       = $clog2(PARAM_WSIZE + PARAM_F)
) (
   input  logic [PTR_W-1:0]             ptr,
   input  logic [7:0]                   nz_eff,
   input  logic [PARAM_WSIZE-1:0][15:0] tile_wts,
   input  logic [PARAM_WSIZE-1:0][7:0]  tile_ind,
`ifdef SCNN_WT_ABS_POS_EN
   input  logic [7:0]                   pos_base,
   output logic [7:0]                   pos_next,
`endif
   output logic [PARAM_F-1:0][15:0]     lane_wts,
   output logic [PARAM_F-1:0][7:0]      lane_ind,
   output logic [PARAM_F-1:0]           lane_vld,
   output logic                         last
);

   // Each lane k reads entry ptr+k through an explicit compare-select so the
   // index never runs past the tile array. With absolute positions enabled,
   // a running sum walks across the lanes: pos_j = sum(ind_0..ind_j) + j.
   always_comb begin
      logic [31:0] idx;
      wt_t         w;
      idx_t        d;
`ifdef SCNN_WT_ABS_POS_EN
      idx_t        run;
      run = pos_base;
`endif
      idx      = '0;
      w        = '0;
      d        = '0;
      lane_wts = '0;
      lane_ind = '0;
      lane_vld = '0;
      for (int k = 0; k < PARAM_F; k++) begin
         idx = 32'(ptr) + 32'(k);
         w   = '0;
         d   = '0;
         for (int i = 0; i < PARAM_WSIZE; i++) begin
            if (idx == 32'(i)) begin
               w = tile_wts[i];
               d = tile_ind[i];
            end
         end
`ifdef SCNN_WT_ABS_POS_EN
         run = run + d;
`endif
         if (idx < 32'(nz_eff)) begin
            lane_vld[k] = 1'b1;
            lane_wts[k] = w;
`ifdef SCNN_WT_ABS_POS_EN
            lane_ind[k] = run;
`else
            lane_ind[k] = d;
`endif
         end
`ifdef SCNN_WT_ABS_POS_EN
         run = run + 8'd1;
`endif
      end
`ifdef SCNN_WT_ABS_POS_EN
      pos_next = run;
`endif
   end

   // The last beat is the one whose window reaches nz_eff; nz_eff=0 makes the
   // very first beat last so an empty tile still marks its boundary.
   assign last = (32'(nz_eff) <= (32'(ptr) + 32'(PARAM_F)));

endmodule

// File: rtl/scnn_wt_stream_sched.sv
// ---------------------------------------------------------------------------
// scnn_wt_stream_sched
// Captures one compressed weight tile and streams it to the PE multiplier
// array as beats of PARAM_F weight/index lanes, flagging the final beat.
//   clk, rst      rising-edge clock, synchronous active-high reset
//   load_valid    tile offered          load_ready  scheduler can capture
//   load_nz       non-zero count        load_wts    packed weights
//   load_ind      zero-run indices
//   out_valid     beat valid            out_ready   array accepts beat
//   out_wts       beat weights          out_ind     beat indices
//   out_lane_vld  per-lane valid        out_last    final beat of tile
//   busy          tile held             nz_err      sticky oversize count
// Macro SCNN_WT_ABS_POS_EN: out_ind carries absolute kernel positions.
// All outputs are decoded from registered state only, so the beat stays
// bit-stable while the array stalls and clears on the cycle after rst.
// ---------------------------------------------------------------------------
module scnn_wt_stream_sched
   import scnn_wt_pkg::*;
#(
   parameter int PARAM_WSIZE = DEF_WSIZE,
   parameter int PARAM_F     = DEF_F
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load_valid,
   output logic                         load_ready,
   input  logic [7:0]                   load_nz,
   input  logic [PARAM_WSIZE-1:0][15:0] load_wts,
   input  logic [PARAM_WSIZE-1:0][7:0]  load_ind,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PARAM_F-1:0][15:0]     out_wts,
   output logic [PARAM_F-1:0][7:0]      out_ind,
   output logic [PARAM_F-1:0]           out_lane_vld,
   output logic                         out_last,
   output logic                         busy,
   output logic                         nz_err
);

   localparam int PTR_W = $clog2(PARAM_WSIZE + PARAM_F);

   sched_state_t                 state;
   sched_state_t                 state_nxt;
   logic                         capture;
   logic                         advance;
   logic [PTR_W-1:0]             ptr;
   logic [7:0]                   nz_eff;
   logic [PARAM_WSIZE-1:0][15:0] tile_wts;
   logic [PARAM_WSIZE-1:0][7:0]  tile_ind;
   logic [PARAM_F-1:0][15:0]     lane_wts;
   logic [PARAM_F-1:0][7:0]      lane_ind;
   logic [PARAM_F-1:0]           lane_vld;
   logic                         lane_last;
`ifdef SCNN_WT_ABS_POS_EN
   logic [7:0]                   pos_base;
   logic [7:0]                   pos_next;
`endif

   // Next-state logic: capture only from IDLE, advance the pointer on a
   // non-final handshake, fall back to IDLE on the final handshake.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      advance   = 1'b0;
      case (state)
         IDLE: begin
            if (load_valid) begin
               capture   = 1'b1;
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (lane_last) begin
                  state_nxt = IDLE;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Beat pointer, clamped count and sticky error. Clamping the count keeps
   // every later compare inside the tile even if the compressor overreports.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr    <= '0;
         nz_eff <= '0;
         nz_err <= 1'b0;
`ifdef SCNN_WT_ABS_POS_EN
         pos_base <= '0;
`endif
      end else if (capture) begin
         ptr    <= '0;
         nz_eff <= (load_nz > 8'(PARAM_WSIZE)) ? 8'(PARAM_WSIZE) : load_nz;
         if (load_nz > 8'(PARAM_WSIZE)) begin
            nz_err <= 1'b1;
         end
`ifdef SCNN_WT_ABS_POS_EN
         pos_base <= '0;
`endif
      end else if (advance) begin
         ptr <= ptr + PTR_W'(PARAM_F);
`ifdef SCNN_WT_ABS_POS_EN
         pos_base <= pos_next;
`endif
      end
   end

   // Tile storage needs no reset: it is only observed while in STREAM,
   // which is always entered through a capture.
   always_ff @(posedge clk) begin
      if (!rst && capture) begin
         tile_wts <= load_wts;
         tile_ind <= load_ind;
      end
   end

   scnn_wt_beat_slice #(
      .PARAM_WSIZE (PARAM_WSIZE),
      .PARAM_F     (PARAM_F),
      .PTR_W       (PTR_W)
   ) u_slice (
      .ptr      (ptr),
      .nz_eff   (nz_eff),
      .tile_wts (tile_wts),
      .tile_ind (tile_ind),
`ifdef SCNN_WT_ABS_POS_EN
      .pos_base (pos_base),
      .pos_next (pos_next),
`endif
      .lane_wts (lane_wts),
      .lane_ind (lane_ind),
      .lane_vld (lane_vld),
      .last     (lane_last)
   );

   assign load_ready   = (state == IDLE);
   assign busy         = (state == STREAM);
   assign out_valid    = busy;
   assign out_wts      = busy ? lane_wts : '0;
   assign out_ind      = busy ? lane_ind : '0;
   assign out_lane_vld = busy ? lane_vld : '0;
   assign out_last     = busy & lane_last;

endmodule

// File: tb/tb_scnn_wt_stream_sched.sv
// ---------------------------------------------------------------------------
// tb_scnn_wt_stream_sched
// Directed bench for scnn_wt_stream_sched with WSIZE=25, F=4. Inputs change
// 1ns after the rising edge and outputs are sampled there too.
// Macro SCNN_WT_ABS_POS_EN switches the expected out_ind values.
// ---------------------------------------------------------------------------
module tb_scnn_wt_stream_sched;

   localparam int WSIZE = 25;
   localparam int F     = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   load_valid;
   logic                   load_ready;
   logic [7:0]             load_nz;
   logic [WSIZE-1:0][15:0] load_wts;
   logic [WSIZE-1:0][7:0]  load_ind;
   logic                   out_valid;
   logic                   out_ready;
   logic [F-1:0][15:0]     out_wts;
   logic [F-1:0][7:0]      out_ind;
   logic [F-1:0]           out_lane_vld;
   logic                   out_last;
   logic                   busy;
   logic                   nz_err;

   int n_checks = 0;
   int n_fail   = 0;

   scnn_wt_stream_sched #(
      .PARAM_WSIZE (WSIZE),
      .PARAM_F     (F)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_nz      (load_nz),
      .load_wts     (load_wts),
      .load_ind     (load_ind),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_wts      (out_wts),
      .out_ind      (out_ind),
      .out_lane_vld (out_lane_vld),
      .out_last     (out_last),
      .busy         (busy),
      .nz_err       (nz_err)
   );

   always #5 clk = ~clk;

   // Hard time limit so a stuck DUT still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected index for tile entry j, from the bench's own copy of the tile.
   function automatic logic [7:0] exp_ind(input int j);
`ifdef SCNN_WT_ABS_POS_EN
      logic [7:0] s;
      s = 8'd0;
      for (int i = 0; i <= j; i++) s = s + load_ind[i];
      return s + 8'(j);
`else
      return load_ind[j];
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_tile();
      for (int i = 0; i < WSIZE; i++) begin
         load_wts[i] = 16'(32'h1000 + i * 3);
         load_ind[i] = 8'(i % 3);
      end
   endtask

   // Offer a tile for one cycle; the caller ensures the DUT is in IDLE.
   task automatic load_tile(input logic [7:0] nz);
      load_nz    = nz;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
      n_checks++; if (out_lane_vld !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_lane_vld: got %b expected 0000", out_lane_vld); end
      n_checks++; if (out_wts !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_out_wts: got %h expected 0", out_wts); end
      n_checks++; if (out_ind !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_out_ind: got %h expected 0", out_ind); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (nz_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_nz_err: got %b expected 0", nz_err); end
      n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_load_ready: got %b expected 1", load_ready); end
   endtask

   // nz=10 at full throughput: beats 1111, 1111, 0011 on consecutive cycles.
   task automatic test_basic_stream();
      logic [3:0] exp_vld [3];
      logic [15:0] ew;
      logic [7:0]  ei;
      int j;
      exp_vld = '{4'b1111, 4'b1111, 4'b0011};
      fill_tile();
      out_ready = 1'b1;
      load_tile(8'd10);
      for (int b = 0; b < 3; b++) begin
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid beat%0d: got %b expected 1", b, out_valid); end
         n_checks++; if (out_lane_vld !== exp_vld[b]) begin n_fail++; $display("[TB] FAIL basic_lane_vld beat%0d: got %b expected %b", b, out_lane_vld, exp_vld[b]); end
         n_checks++; if (out_last !== (b == 2)) begin n_fail++; $display("[TB] FAIL basic_last beat%0d: got %b expected %b", b, out_last, (b == 2)); end
         for (int k = 0; k < F; k++) begin
            j  = b * F + k;
            ew = (j < 10) ? load_wts[j] : 16'd0;
            ei = (j < 10) ? exp_ind(j) : 8'd0;
            n_checks++; if (out_wts[k] !== ew) begin n_fail++; $display("[TB] FAIL basic_wts beat%0d lane%0d: got %h expected %h", b, k, out_wts[k], ew); end
            n_checks++; if (out_ind[k] !== ei) begin n_fail++; $display("[TB] FAIL basic_ind beat%0d lane%0d: got %h expected %h", b, k, out_ind[k], ei); end
         end
         tick();
      end
      n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_ready_after: got %b expected 1", load_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_valid_after: got %b expected 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy_after: got %b expected 0", busy); end
   endtask

   // nz=0 still produces exactly one empty, last beat.
   task automatic test_zero_nz();
      out_ready = 1'b1;
      load_tile(8'd0);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_valid: got %b expected 1", out_valid); end
      n_checks++; if (out_lane_vld !== 4'b0000) begin n_fail++; $display("[TB] FAIL zero_lane_vld: got %b expected 0000", out_lane_vld); end
      n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_last: got %b expected 1", out_last); end
      n_checks++; if (out_wts !== 64'd0) begin n_fail++; $display("[TB] FAIL zero_wts: got %h expected 0", out_wts); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_valid_after: got %b expected 0", out_valid); end
      n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_ready_after: got %b expected 1", load_ready); end
   endtask

   // nz=5 with three stall cycles on beat 1, then beat 2 carries entry 4 only.
   task automatic test_backpressure();
      logic [63:0] ew;
      logic [31:0] ei;
      fill_tile();
      out_ready = 1'b0;
      load_tile(8'd5);
      ew = {load_wts[3], load_wts[2], load_wts[1], load_wts[0]};
      ei = {exp_ind(3), exp_ind(2), exp_ind(1), exp_ind(0)};
      for (int c = 0; c < 4; c++) begin
         if (c == 3) out_ready = 1'b1;
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_valid cyc%0d: got %b expected 1", c, out_valid); end
         n_checks++; if (out_lane_vld !== 4'b1111) begin n_fail++; $display("[TB] FAIL bp_lane_vld cyc%0d: got %b expected 1111", c, out_lane_vld); end
         n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_last cyc%0d: got %b expected 0", c, out_last); end
         n_checks++; if (out_wts !== ew) begin n_fail++; $display("[TB] FAIL bp_wts cyc%0d: got %h expected %h", c, out_wts, ew); end
         n_checks++; if (out_ind !== ei) begin n_fail++; $display("[TB] FAIL bp_ind cyc%0d: got %h expected %h", c, out_ind, ei); end
         tick();
      end
      n_checks++; if (out_lane_vld !== 4'b0001) begin n_fail++; $display("[TB] FAIL bp_beat2_vld: got %b expected 0001", out_lane_vld); end
      n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_beat2_last: got %b expected 1", out_last); end
      n_checks++; if (out_wts !== {48'd0, load_wts[4]}) begin n_fail++; $display("[TB] FAIL bp_beat2_wts: got %h expected %h", out_wts, {48'd0, load_wts[4]}); end
      n_checks++; if (out_ind !== {24'd0, exp_ind(4)}) begin n_fail++; $display("[TB] FAIL bp_beat2_ind: got %h expected %h", out_ind, {24'd0, exp_ind(4)}); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_valid_after: got %b expected 0", out_valid); end
   endtask

   // load_nz=30 clamps to 25 (7 beats) and sets the sticky error.
   task automatic test_nz_overflow();
      int  beats;
      logic done;
      beats = 0;
      done  = 1'b0;
      fill_tile();
      out_ready = 1'b1;
      load_tile(8'd30);
      n_checks++; if (nz_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_nz_err: got %b expected 1", nz_err); end
      for (int c = 0; c < 20 && !done; c++) begin
         if (out_valid) begin
            beats++;
            if (out_last) begin
               done = 1'b1;
               n_checks++; if (out_lane_vld !== 4'b0001) begin n_fail++; $display("[TB] FAIL ovf_last_vld: got %b expected 0001", out_lane_vld); end
               n_checks++; if (out_wts[0] !== load_wts[24]) begin n_fail++; $display("[TB] FAIL ovf_last_wts: got %h expected %h", out_wts[0], load_wts[24]); end
            end
         end
         tick();
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_timeout: got no last beat expected one within 20 cycles"); end
      n_checks++; if (beats !== 7) begin n_fail++; $display("[TB] FAIL ovf_beats: got %0d expected 7", beats); end
      load_tile(8'd4);
      n_checks++; if (nz_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sticky: got %b expected 1", nz_err); end
      n_checks++; if (out_lane_vld !== 4'b1111) begin n_fail++; $display("[TB] FAIL ovf_next_vld: got %b expected 1111", out_lane_vld); end
      n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_next_last: got %b expected 1", out_last); end
      tick();
      n_checks++; if (nz_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sticky_after: got %b expected 1", nz_err); end
   endtask

   // rst on beat 2 of a 10-weight tile discards it; a following tile works.
   task automatic test_reset_mid_tile();
      fill_tile();
      out_ready = 1'b1;
      load_tile(8'd10);
      tick();
      n_checks++; if (out_wts[0] !== load_wts[4]) begin n_fail++; $display("[TB] FAIL rstmid_beat2: got %h expected %h", out_wts[0], load_wts[4]); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_valid: got %b expected 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
      n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_ready: got %b expected 1", load_ready); end
      n_checks++; if (nz_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_nz_err: got %b expected 0", nz_err); end
      n_checks++; if (out_lane_vld !== 4'b0000) begin n_fail++; $display("[TB] FAIL rstmid_lane_vld: got %b expected 0000", out_lane_vld); end
      load_tile(8'd2);
      n_checks++; if (out_lane_vld !== 4'b0011) begin n_fail++; $display("[TB] FAIL rstmid_new_vld: got %b expected 0011", out_lane_vld); end
      n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_new_last: got %b expected 1", out_last); end
      n_checks++; if (out_wts !== {32'd0, load_wts[1], load_wts[0]}) begin n_fail++; $display("[TB] FAIL rstmid_new_wts: got %h expected %h", out_wts, {32'd0, load_wts[1], load_wts[0]}); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_new_after: got %b expected 0", out_valid); end
   endtask

   // Weights at kernel positions 0, 3, 4 (runs 0, 2, 0).
   task automatic test_index_mode();
      logic [31:0] ei;
`ifdef SCNN_WT_ABS_POS_EN
      ei = {8'd0, 8'd4, 8'd3, 8'd0};
`else
      ei = {8'd0, 8'd0, 8'd2, 8'd0};
`endif
      fill_tile();
      load_wts[0] = 16'h00A0; load_wts[1] = 16'h00B0; load_wts[2] = 16'h00C0;
      load_ind[0] = 8'd0;     load_ind[1] = 8'd2;     load_ind[2] = 8'd0;
      out_ready = 1'b1;
      load_tile(8'd3);
      n_checks++; if (out_lane_vld !== 4'b0111) begin n_fail++; $display("[TB] FAIL idx_lane_vld: got %b expected 0111", out_lane_vld); end
      n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("[TB] FAIL idx_last: got %b expected 1", out_last); end
      n_checks++; if (out_wts !== 64'h0000_00C0_00B0_00A0) begin n_fail++; $display("[TB] FAIL idx_wts: got %h expected 000000c000b000a0", out_wts); end
      n_checks++; if (out_ind !== ei) begin n_fail++; $display("[TB] FAIL idx_ind: got %h expected %h", out_ind, ei); end
      tick();
   endtask

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      out_ready  = 1'b0;
      load_nz    = 8'd0;
      fill_tile();
      test_reset();
      test_basic_stream();
      test_zero_nz();
      test_backpressure();
      test_nz_overflow();
      test_reset_mid_tile();
      test_index_mode();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/scnn_wt_stream_sched.md
Name: scnn_wt_stream_sched

Overview:
- Sequencer between the weight-compression stage and the PE multiplier array.
- Captures one compressed weight tile per load: non-zero count, packed values and zero-run indices.
- Streams the tile as beats of PARAM_F weight/index lanes over a valid/ready handshake and flags the last beat.
- Lets one compressor feed a multiplier array narrower than the tile, and gives the PE control a clean tile boundary.

Parameters:
- PARAM_WSIZE, 25: weights per tile; compressed-vector depth; max 255.
- PARAM_F, 4: lanes per output beat; 1..PARAM_WSIZE.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- load_valid  in  1  tile offered
- load_ready  out  1  scheduler can capture a tile
- load_nz  in  8  non-zero count of offered tile
- load_wts  in  [PARAM_WSIZE-1:0][15:0]  packed non-zero weights, index 0 first
- load_ind  in  [PARAM_WSIZE-1:0][7:0]  zero-run length preceding each packed weight
- out_valid  out  1  beat valid
- out_ready  in  1  multiplier array accepts beat
- out_wts  out  [PARAM_F-1:0][15:0]  beat weights
- out_ind  out  [PARAM_F-1:0][7:0]  beat indices
- out_lane_vld  out  PARAM_F  per-lane valid
- out_last  out  1  final beat of tile
- busy  out  1  tile held
- nz_err  out  1  sticky: a load_nz > PARAM_WSIZE was seen

Behaviour:
- Reset values (registered outputs):
  - out_valid=0, out_last=0, out_lane_vld=0, out_wts=0, out_ind=0, busy=0, nz_err=0.
  - State=IDLE. Takes effect on the first clk edge with rst=1, including mid-tile; the held tile is discarded and no further beats are issued.
- States: IDLE, STREAM.
- IDLE:
  - load_ready=1.
  - On load_valid, capture the tile and set nz_eff=min(load_nz, PARAM_WSIZE) and ptr=0.
  - If load_nz > PARAM_WSIZE, set nz_err (sticky until rst).
  - Go to STREAM. out_valid rises the cycle after capture (1-cycle load-to-beat latency).
- STREAM:
  - load_ready=0; busy=1.
  - Beat content: lane k carries entry ptr+k; out_lane_vld[k]=(ptr+k < nz_eff). Invalid lanes drive wts=0, ind=0.
  - out_last=1 when ptr+PARAM_F >= nz_eff.
  - Beat outputs are held stable while out_valid && !out_ready.
  - On handshake with !out_last: ptr += PARAM_F and the next beat is presented the following cycle.
  - On handshake with out_last: return to IDLE; out_valid, busy and out_last drop next cycle.
- Beats per tile: ceil(nz_eff/PARAM_F). nz_eff=0 issues exactly one beat with out_lane_vld=0 and out_last=1, so tile boundaries are never lost.
- Minimum cost is one idle cycle between tiles (load only accepted in IDLE).
- load_valid during STREAM is ignored; the producer must hold it.
- load_valid with rst=1: rst wins and no capture occurs.
- ptr width is $clog2(PARAM_WSIZE+PARAM_F); compares are unsigned; no wrap is possible.

Optional Feature:
- Macro: SCNN_WT_ABS_POS_EN.
- Defined:
  - out_ind carries the absolute kernel position of each weight, pos_j = sum over i<=j of ind_i, plus j.
  - Computed by a running 8-bit accumulator carried across beats; reset to 0 at capture.
  - Invalid lanes drive 0.
- Undefined: out_ind is the raw zero-run index; the accumulator is absent.

Decomposition:
- Package scnn_wt_pkg:
  - localparams for default WSIZE/F, weight width 16 and index width 8.
  - typedefs wt_t, idx_t.
  - enum sched_state_t {IDLE, STREAM}.
- One sub-module: scnn_wt_beat_slice. It is the combinational lane selector (ptr, nz_eff, tile → lane data and valid) plus the optional position accumulator. The FSM stays in the top.

Test Plan:
- WSIZE=25, F=4, nz=10, out_ready=1:
  - 3 beats on consecutive cycles with lane_vld 1111, 1111, 0011.
  - out_last on beat 3; load_ready back high the cycle after.
- nz=0 → single beat, lane_vld=0000, out_last=1, out_wts=0.
- nz=5, out_ready low 3 cycles on beat 1 → beat 1 held bit-stable throughout. Beat 2 = entry 4 only (lane_vld 0001) after the handshake.
- load_nz=30 → nz_err=1 and 7 beats (nz_eff=25). nz_err stays set across the following tile with nz=4.
- rst asserted on beat 2 of a 10-weight tile → next cycle out_valid=0, busy=0, load_ready=1. A new tile with nz=2 streams correctly.
- Tile with weights at kernel positions 0, 3, 4 (ind 0, 2, 0):
  - Without SCNN_WT_ABS_POS_EN: out_ind = 0, 2, 0.
  - With SCNN_WT_ABS_POS_EN: out_ind = 0, 3, 4.
